bwt_mem_responder: RTL

Memory-side responder for the backward-extension control pipeline's occurrence-table requests. Accepts each tagged request (read number plus `addr_k`/`addr_l` cache-line addresses) into a small FIFO. Issues the one or two cache-line reads to the memory port and collects the returns, which may arrive out of order. Presents both 512-bit lines together with the read number to the bwt_extend side, holding them under `stall`.

---
 rtl/bwt_mem_pkg.sv | 19 +
 rtl/bwt_req_fifo.sv | 53 +++++
 rtl/bwt_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bwt_mem_pkg.sv
// Shared types and constants for the occurrence-table memory responder.
package bwt_mem_pkg;

  localparam int CL_DEFAULT         = 512;
  localparam int ADDR_WIDTH_DEFAULT = 42;

  // Memory read/return tag: which of the two lines a beat belongs to.
  localparam logic TAG_K = 1'b0;
  localparam logic TAG_L = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_K,
    ST_ISSUE_L,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/bwt_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two (>= 2) so the
// pointers wrap on their own.
module bwt_req_fifo #(
  parameter int WIDTH = 94,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bwt_mem_responder.sv
// Memory-side responder: queues tagged k/l line requests, issues the one or
// two cache-line reads, gathers out-of-order returns and presents both lines.
module bwt_mem_responder
  import bwt_mem_pkg::*;
#(
  parameter int READ_NUM_WIDTH = 10,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int CL             = CL_DEFAULT,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [READ_NUM_WIDTH-1:0] req_read_num,
  input  logic [ADDR_WIDTH-1:0]     req_addr_k,
  input  logic [ADDR_WIDTH-1:0]     req_addr_l,
  output logic                      req_ready,
  output logic                      mem_rd_valid,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  output logic                      mem_rd_tag,
  input  logic                      mem_rd_ready,
  input  logic                      mem_rsp_valid,
  input  logic                      mem_rsp_tag,
  input  logic [CL-1:0]             mem_rsp_data,
  input  logic                      stall,
  output logic                      rsp_valid,
  output logic [READ_NUM_WIDTH-1:0] rsp_read_num,
  output logic [CL-1:0]             rsp_cl_k,
  output logic [CL-1:0]             rsp_cl_l,
  output logic                      err
);

  localparam int EW = READ_NUM_WIDTH + 2*ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

  state_t state_q, state_d;

  logic [EW-1:0]             fifo_rdata;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]             fifo_count;
  logic [READ_NUM_WIDTH-1:0] h_rn;
  logic [ADDR_WIDTH-1:0]     h_ak, h_al;

  logic [READ_NUM_WIDTH-1:0] rn_q;
  logic [ADDR_WIDTH-1:0]     addr_k_q, addr_l_q;
  logic [CL-1:0]             cl_k_q, cl_l_q;
  logic                      same_q, got_k_q, got_l_q, err_q;
  logic                      rsp_window, take_k, take_l, rsp_bad;

  assign req_ready = (fifo_count != FULL_CNT);
  assign fifo_push = req_valid & ~fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;
  assign {h_rn, h_ak, h_al} = fifo_rdata;

  bwt_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({req_read_num, req_addr_k, req_addr_l}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: one request in flight; stall only holds OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!fifo_empty)        state_d = ST_ISSUE_K;
      ST_ISSUE_K: if (mem_rd_ready)       state_d = same_q ? ST_WAIT : ST_ISSUE_L;
      ST_ISSUE_L: if (mem_rd_ready)       state_d = ST_WAIT;
      ST_WAIT:    if (got_k_q && got_l_q) state_d = ST_OUT;
      ST_OUT:     if (!stall)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; result data comes straight from the working registers.
  always_comb begin
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    mem_rd_tag   = TAG_K;
    rsp_valid    = 1'b0;
    case (state_q)
      ST_ISSUE_K: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = addr_k_q;
        mem_rd_tag   = TAG_K;
      end
      ST_ISSUE_L: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = addr_l_q;
        mem_rd_tag   = TAG_L;
      end
      ST_OUT:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_read_num = rn_q;
  assign rsp_cl_k     = cl_k_q;
  assign rsp_cl_l     = cl_l_q;
  assign err          = err_q;

  // Classify a return beat. Before the k read is accepted nothing can be
  // outstanding, so a beat in ISSUE_K is treated like one in IDLE/OUT.
  always_comb begin
    rsp_window = (state_q == ST_ISSUE_L) || (state_q == ST_WAIT);
    take_k     = mem_rsp_valid & rsp_window & (mem_rsp_tag == TAG_K) & ~got_k_q;
    take_l     = mem_rsp_valid & rsp_window & (mem_rsp_tag == TAG_L) & ~same_q & ~got_l_q;
    rsp_bad    = mem_rsp_valid & ~take_k & ~take_l;
  end

  // Working registers: load on pop, then fill lines as returns land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rn_q     <= '0;
      addr_k_q <= '0;
      addr_l_q <= '0;
      same_q   <= 1'b0;
      got_k_q  <= 1'b0;
      got_l_q  <= 1'b0;
      cl_k_q   <= '0;
      cl_l_q   <= '0;
    end else if (fifo_pop) begin
      rn_q     <= h_rn;
      addr_k_q <= h_ak;
      addr_l_q <= h_al;
      same_q   <= (h_ak == h_al);
      got_k_q  <= 1'b0;
      got_l_q  <= 1'b0;
    end else begin
      if (take_k) begin
        cl_k_q  <= mem_rsp_data;
        got_k_q <= 1'b1;
        if (same_q) begin
          cl_l_q  <= mem_rsp_data;
          got_l_q <= 1'b1;
        end
      end
      if (take_l) begin
        cl_l_q  <= mem_rsp_data;
        got_l_q <= 1'b1;
      end
    end
  end

  // Sticky protocol error; offending beats are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (rsp_bad) err_q <= 1'b1;
  end

endmodule
